// File: rtl/fp_addsub_if.sv
// Operand/result stream bundle for the pipelined FP adder/subtractor.
// The block sits on the slave side; operand producers and result consumers
// together form the master side.
interface fp_addsub_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
);
    localparam int FLOAT_W = 1 + EXP_W + MAN_W;

    logic               in_valid;
    logic               in_ready;
    logic [FLOAT_W-1:0] in_a;
    logic [FLOAT_W-1:0] in_b;
    logic               in_sub;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [FLOAT_W-1:0] out_res;
    logic [TAG_W-1:0]   out_tag;
    logic [3:0]         out_flags;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag, out_flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// 3-stage pipelined floating-point adder/subtractor, round-to-nearest-even.
//   S1: unpack, special-case resolve, swap by magnitude, align with G/R/S
//   S2: effective add (carry renormalise) or subtract
//   S3: leading-one normalise, round, overflow/underflow, pack
// Exponents stay in biased form throughout, so the bias never has to be
// added or removed; subnormal inputs flush to zero and subnormal results
// flush to signed zero with underflow.
// Flags are {invalid, overflow, underflow, inexact}, per result.
module fp_addsub_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    fp_addsub_if.slave    io
);
    localparam int FLOAT_W = 1 + EXP_W + MAN_W;
    localparam int SW      = MAN_W + 1;          // significand incl. hidden bit
    localparam int AW      = MAN_W + 3;          // significand + guard + round
    localparam int W       = MAN_W + 4;          // significand + G + R + sticky
    localparam int XW      = EXP_W + 2;          // signed exponent arithmetic
    localparam int SHW     = $clog2(AW + 1);
    localparam int LZW     = $clog2(W);

    localparam logic [EXP_W-1:0]   EXP_ONES = '1;
    localparam logic [FLOAT_W-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic               sign;        // sign of the larger magnitude
        logic [EXP_W-1:0]   exp;         // exponent of the larger magnitude
        logic [SW-1:0]      big_sig;
        logic [W-1:0]       small_sig;   // aligned, with G/R/S in the low 3 bits
        logic               eff_sub;
        logic               special;     // result already decided in S1
        logic [FLOAT_W-1:0] spec_res;
        logic [3:0]         spec_flags;
        logic [TAG_W-1:0]   tag;
    } s1_t;

    typedef struct packed {
        logic               sign;
        logic [XW-1:0]      exp;
        logic [W-1:0]       mag;
        logic               special;
        logic [FLOAT_W-1:0] spec_res;
        logic [3:0]         spec_flags;
        logic [TAG_W-1:0]   tag;
    } s2_t;

    logic [3:1] vld_pipe;
    logic       advance;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    logic [FLOAT_W-1:0] res_d, res_q;
    logic [3:0]         flags_d, flags_q;
    logic [TAG_W-1:0]   tag_q;

    // Whole pipe moves together whenever the output slot is free or drained
    assign advance      = !vld_pipe[3] || io.out_ready;
    assign io.in_ready  = advance;
    assign io.out_valid = vld_pipe[3];
    assign io.out_res   = res_q;
    assign io.out_tag   = tag_q;
    assign io.out_flags = flags_q;

    // ---------------- S1: unpack / special / swap / align ----------------
    logic               a_sign, b_sign;
    logic [EXP_W-1:0]   a_exp, b_exp, exp_diff, small_exp;
    logic [MAN_W-1:0]   a_man, b_man, a_manf, b_manf, big_man, small_man;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;
    logic               small_sign;
    logic [SHW-1:0]     sh;
    logic [2*AW-1:0]    wide;

    // Classify operands, resolve special results, order by magnitude, align
    always_comb begin
        s1_d      = '0;
        a_sign    = io.in_a[FLOAT_W-1];
        a_exp     = io.in_a[FLOAT_W-2:MAN_W];
        a_man     = io.in_a[MAN_W-1:0];
        b_sign    = io.in_b[FLOAT_W-1] ^ io.in_sub;
        b_exp     = io.in_b[FLOAT_W-2:MAN_W];
        b_man     = io.in_b[MAN_W-1:0];

        a_zero    = (a_exp == '0);
        b_zero    = (b_exp == '0);
        a_inf     = (a_exp == EXP_ONES) && (a_man == '0);
        b_inf     = (b_exp == EXP_ONES) && (b_man == '0);
        a_nan     = (a_exp == EXP_ONES) && (a_man != '0);
        b_nan     = (b_exp == EXP_ONES) && (b_man != '0);
        // subnormal mantissas are discarded so they compare as zero
        a_manf    = a_zero ? '0 : a_man;
        b_manf    = b_zero ? '0 : b_man;
        a_ge      = {a_exp, a_manf} >= {b_exp, b_manf};

        s1_d.sign = a_ge ? a_sign : b_sign;
        s1_d.exp  = a_ge ? a_exp  : b_exp;
        big_man   = a_ge ? a_manf : b_manf;
        small_exp = a_ge ? b_exp  : a_exp;
        small_man = a_ge ? b_manf : a_manf;
        small_sign = a_ge ? b_sign : a_sign;

        s1_d.eff_sub = s1_d.sign ^ small_sign;
        s1_d.big_sig = {1'b1, big_man};

        // shift distance saturates where the whole significand lands in sticky
        exp_diff  = s1_d.exp - small_exp;
        if (int'(exp_diff) >= AW) sh = SHW'(AW);
        else                      sh = SHW'(exp_diff);
        wide      = {{(small_exp != '0), small_man, 2'b00}, {AW{1'b0}}} >> sh;
        s1_d.small_sig = {wide[2*AW-1:AW], |wide[AW-1:0]};

        s1_d.tag     = io.in_tag;
        s1_d.special = 1'b1;
        if (a_nan || b_nan) begin
            s1_d.spec_res = QNAN;
        end else if (a_inf && b_inf) begin
            if (a_sign != b_sign) begin
                s1_d.spec_res   = QNAN;
                s1_d.spec_flags = 4'b1000;
            end else begin
                s1_d.spec_res   = io.in_a;
            end
        end else if (a_inf) begin
            s1_d.spec_res = io.in_a;
        end else if (b_inf) begin
            s1_d.spec_res = {b_sign, b_exp, b_man};
        end else if (a_zero && b_zero) begin
            // only -0 + -0 keeps the minus sign
            s1_d.spec_res = {a_sign & b_sign, {(FLOAT_W-1){1'b0}}};
        end else if (a_zero) begin
            s1_d.spec_res = {b_sign, b_exp, b_man};
        end else if (b_zero) begin
            s1_d.spec_res = io.in_a;
        end else begin
            s1_d.special  = 1'b0;
        end
    end

    // ---------------- S2: effective add / subtract ----------------
    logic [W-1:0] big_ext;
    logic [W:0]   sum;

    // Sticky rides as the LSB so subtraction borrows stay RNE-correct
    always_comb begin
        s2_d            = '0;
        s2_d.sign       = s1_q.sign;
        s2_d.special    = s1_q.special;
        s2_d.spec_res   = s1_q.spec_res;
        s2_d.spec_flags = s1_q.spec_flags;
        s2_d.tag        = s1_q.tag;
        big_ext         = {s1_q.big_sig, 3'b000};
        sum             = {1'b0, big_ext} + {1'b0, s1_q.small_sig};
        s2_d.exp        = {2'b00, s1_q.exp};
        if (s1_q.eff_sub) begin
            s2_d.mag = big_ext - s1_q.small_sig;
        end else if (sum[W]) begin
            s2_d.mag = {sum[W:2], sum[1] | sum[0]};
            s2_d.exp = {2'b00, s1_q.exp} + XW'(1);
        end else begin
            s2_d.mag = sum[W-1:0];
        end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic [LZW-1:0]   lz;
    logic [W-1:0]     mag_n;
    logic [XW-1:0]    exp_n, exp_f;
    logic [SW-1:0]    sig;
    logic [SW:0]      sig_r;
    logic [MAN_W-1:0] man_f;
    logic             g_bit, r_bit, s_bit, rnd_up, inexact;

    // Leading-one detect over the full significand
    always_comb begin
        lz = '0;
        for (int i = 0; i < W; i++)
            if (s2_q.mag[i]) lz = LZW'(W - 1 - i);
    end

    // Normalise, round to nearest even, then range-check the exponent
    always_comb begin
        mag_n   = s2_q.mag << lz;
        exp_n   = s2_q.exp - XW'(lz);
        sig     = mag_n[W-1:3];
        g_bit   = mag_n[2];
        r_bit   = mag_n[1];
        s_bit   = mag_n[0];
        rnd_up  = g_bit & (r_bit | s_bit | sig[0]);
        inexact = g_bit | r_bit | s_bit;
        sig_r   = {1'b0, sig} + (SW+1)'(rnd_up);
        if (sig_r[SW]) begin
            man_f = sig_r[MAN_W:1];
            exp_f = exp_n + XW'(1);
        end else begin
            man_f = sig_r[MAN_W-1:0];
            exp_f = exp_n;
        end

        if (s2_q.special) begin
            res_d   = s2_q.spec_res;
            flags_d = s2_q.spec_flags;
        end else if (s2_q.mag == '0) begin
            // exact cancellation always yields +0
            res_d   = '0;
            flags_d = 4'b0000;
        end else if ($signed(exp_f) >= $signed(XW'({EXP_ONES}))) begin
            res_d   = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_d = 4'b0101;
        end else if ($signed(exp_f) <= $signed(XW'(0))) begin
            res_d   = {s2_q.sign, {(FLOAT_W-1){1'b0}}};
            flags_d = 4'b0011;
        end else begin
            res_d   = {s2_q.sign, exp_f[EXP_W-1:0], man_f};
            flags_d = {3'b000, inexact};
        end
    end

    // Stage registers: all shift on advance, all hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            tag_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[2:1], io.in_valid};
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            tag_q    <= s2_q.tag;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed cases with literal expectations, a
// backpressure burst, a mid-flight reset, then random traffic with random
// consumer stalls, all scored against an exact-integer reference model.
module tb_fp_addsub_pipe;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int TAG_W = 4;
    localparam int FW    = 1 + EXP_W + MAN_W;
    localparam int EMAX  = (1 << EXP_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_addsub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) io();

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    typedef struct {
        logic [FW-1:0]    res;
        logic [TAG_W-1:0] tag;
        logic [3:0]       flg;
        int               cyc;
        logic             lit_vld;
        logic [FW-1:0]    lit_res;
        logic [3:0]       lit_flg;
    } exp_t;

    exp_t             sb[$];
    int               n_chk = 0;
    int               n_err = 0;
    int               cyc   = 0;
    bit               lat_en = 1'b0;
    bit               rnd_done = 1'b0;
    logic             lit_vld = 1'b0;
    logic [FW-1:0]    lit_res = '0;
    logic [3:0]       lit_flg = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact reference: operands become scaled integers, the sum is formed
    // exactly, then rounded to MAN_W+1 significant bits (ties to even).
    function automatic logic [FW+3:0] model(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                            input logic sub);
        logic          sa, sbn, inex, neg;
        int            ea, eb, p, e, sh;
        longint        ma, mb, va, vb, s, mag, q, rem, half;
        logic [FW-1:0] qnan;
        qnan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        sa  = a[FW-1];
        sbn = b[FW-1] ^ sub;
        ea  = int'(a[FW-2:MAN_W]);
        eb  = int'(b[FW-2:MAN_W]);
        ma  = longint'(a[MAN_W-1:0]);
        mb  = longint'(b[MAN_W-1:0]);
        if ((ea == EMAX && ma != 0) || (eb == EMAX && mb != 0)) return {4'b0000, qnan};
        if (ea == EMAX && eb == EMAX)
            return (sa != sbn) ? {4'b1000, qnan} : {4'b0000, a};
        if (ea == EMAX) return {4'b0000, a};
        if (eb == EMAX) return {4'b0000, sbn, b[FW-2:0]};
        if (ea == 0 && eb == 0) return {4'b0000, sa & sbn, {(FW-1){1'b0}}};
        if (ea == 0) return {4'b0000, sbn, b[FW-2:0]};
        if (eb == 0) return {4'b0000, a};
        va = (ma + (longint'(1) << MAN_W)) << (ea - 1);
        vb = (mb + (longint'(1) << MAN_W)) << (eb - 1);
        s  = (sa ? -va : va) + (sbn ? -vb : vb);
        if (s == 0) return '0;
        neg = (s < 0);
        mag = neg ? -s : s;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        e = p + 1 - MAN_W;
        if (p > MAN_W) begin
            sh   = p - MAN_W;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            inex = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end else begin
            q    = mag << (MAN_W - p);
            inex = 1'b0;
        end
        if (q == (longint'(1) << (MAN_W + 1))) begin
            q = q >> 1;
            e++;
        end
        if (e >= EMAX) return {4'b0101, neg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        if (e <= 0)    return {4'b0011, neg, {(FW-1){1'b0}}};
        return {3'b000, inex, neg, e[EXP_W-1:0], q[MAN_W-1:0]};
    endfunction

    function automatic logic [FW-1:0] rnd_op();
        logic             s;
        logic [EXP_W-1:0] ex;
        logic [MAN_W-1:0] m;
        s  = 1'($urandom_range(0, 1));
        m  = MAN_W'($urandom);
        ex = EXP_W'($urandom_range(1, EMAX - 1));
        case ($urandom_range(0, 11))
            0: begin ex = '0; m = '0; end
            1: begin ex = '1; m = '0; end
            2: begin ex = '1; m[0] = 1'b1; end
            3: ex = '0;
            4: ex = EXP_W'(EMAX - 1);
            5: ex = EXP_W'($urandom_range(1, 3));
            default: ;
        endcase
        return {s, ex, m};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: scoreboard, hold-stability and ready-rule checks
    initial begin : mon
        exp_t          e;
        logic [FW+3:0] r;
        logic          hold_vld;
        logic [FW-1:0] hold_res;
        logic [TAG_W-1:0] hold_tag;
        logic [3:0]    hold_flg;
        hold_vld = 1'b0;
        hold_res = '0;
        hold_tag = '0;
        hold_flg = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                hold_vld = 1'b0;
            end else begin
                chk("in_ready_rule", io.in_ready, !io.out_valid || io.out_ready);
                if (hold_vld) begin
                    chk("hold_valid", io.out_valid, 1);
                    chk("hold_res", io.out_res, hold_res);
                    chk("hold_tag", io.out_tag, hold_tag);
                    chk("hold_flags", io.out_flags, hold_flg);
                end
                if (io.out_valid && io.out_ready) begin
                    if (sb.size() == 0) begin
                        chk("spurious_out", io.out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("res", io.out_res, e.res);
                        chk("tag", io.out_tag, e.tag);
                        chk("flags", io.out_flags, e.flg);
                        if (e.lit_vld) begin
                            chk("lit_res", io.out_res, e.lit_res);
                            chk("lit_flags", io.out_flags, e.lit_flg);
                        end
                        if (lat_en) chk("latency", cyc - e.cyc, 3);
                    end
                end
                hold_vld = io.out_valid && !io.out_ready;
                hold_res = io.out_res;
                hold_tag = io.out_tag;
                hold_flg = io.out_flags;
                if (io.in_valid && io.in_ready) begin
                    r         = model(io.in_a, io.in_b, io.in_sub);
                    e.res     = r[FW-1:0];
                    e.flg     = r[FW+3:FW];
                    e.tag     = io.in_tag;
                    e.cyc     = cyc;
                    e.lit_vld = lit_vld;
                    e.lit_res = lit_res;
                    e.lit_flg = lit_flg;
                    sb.push_back(e);
                end
            end
        end
    end

    // Present one operation and hold it until accepted (bounded)
    task automatic push(input logic [FW-1:0] a, input logic [FW-1:0] b, input logic sub,
                        input logic [TAG_W-1:0] tag, input logic lv,
                        input logic [FW-1:0] lr, input logic [3:0] lf);
        bit done;
        io.in_a     = a;
        io.in_b     = b;
        io.in_sub   = sub;
        io.in_tag   = tag;
        lit_vld     = lv;
        lit_res     = lr;
        lit_flg     = lf;
        io.in_valid = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = io.in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("in_ready_timeout", io.in_ready, 1);
        io.in_valid = 1'b0;
        lit_vld     = 1'b0;
    endtask

    task automatic push_rnd(input logic [TAG_W-1:0] tag);
        logic [FW-1:0] a, b;
        a = rnd_op();
        b = rnd_op();
        if ($urandom_range(0, 3) == 0)
            b = {1'($urandom_range(0, 1)), a[FW-2:0] ^ (FW-1)'($urandom_range(0, 7))};
        push(a, b, 1'($urandom_range(0, 1)), tag, 1'b0, '0, '0);
    endtask

    initial begin
        io.in_valid  = 1'b0;
        io.in_a      = '0;
        io.in_b      = '0;
        io.in_sub    = 1'b0;
        io.in_tag    = '0;
        io.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_out_res", io.out_res, 0);
        chk("rst_out_tag", io.out_tag, 0);
        chk("rst_out_flags", io.out_flags, 0);
        @(posedge clk);
        #1;

        // directed cases, back to back, no stalls
        lat_en = 1'b1;
        push(16'h3C00, 16'h4000, 0, 4'd5,  1, 16'h4200, 4'b0000);
        push(16'h3C00, 16'h3C00, 1, 4'd1,  1, 16'h0000, 4'b0000);
        push(16'h3C00, 16'h1000, 0, 4'd2,  1, 16'h3C00, 4'b0001);
        push(16'h3C01, 16'h1000, 0, 4'd3,  1, 16'h3C02, 4'b0001);
        push(16'h7BFF, 16'h7BFF, 0, 4'd4,  1, 16'h7C00, 4'b0101);
        push(16'h7C00, 16'h7C00, 1, 4'd6,  1, 16'h7E00, 4'b1000);
        push(16'h7E01, 16'h3C00, 0, 4'd7,  1, 16'h7E00, 4'b0000);
        push(16'h0400, 16'h0600, 1, 4'd8,  1, 16'h8000, 4'b0011);
        push(16'h8000, 16'h8000, 0, 4'd9,  1, 16'h8000, 4'b0000);
        push(16'h0000, 16'h8000, 0, 4'd10, 1, 16'h0000, 4'b0000);
        push(16'h0000, 16'hC500, 0, 4'd11, 1, 16'hC500, 4'b0000);
        push(16'hFC00, 16'h3C00, 0, 4'd12, 1, 16'hFC00, 4'b0000);
        push(16'h3C00, 16'h0001, 1, 4'd13, 1, 16'h3C00, 4'b0000);
        repeat (6) @(posedge clk);
        #1 lat_en = 1'b0;

        // backpressure: six ops while the consumer stalls for seven cycles
        fork
            begin
                for (int i = 0; i < 6; i++) push_rnd(TAG_W'(i));
            end
            begin
                @(posedge clk);
                #1 io.out_ready = 1'b0;
                repeat (7) @(posedge clk);
                #1 io.out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;

        // reset with three operations in flight
        lat_en = 1'b1;
        push(16'h4000, 16'h4000, 0, 4'd1, 1'b0, '0, '0);
        push(16'h4400, 16'h3C00, 1, 4'd2, 1'b0, '0, '0);
        push(16'hC000, 16'h3C00, 0, 4'd3, 1'b0, '0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", io.out_valid, 0);
        chk("midrst_out_res", io.out_res, 0);
        chk("midrst_out_tag", io.out_tag, 0);
        @(posedge clk);
        #1;
        push(16'h3C00, 16'h4000, 0, 4'd5, 1, 16'h4200, 4'b0000);
        repeat (6) @(posedge clk);
        #1 lat_en = 1'b0;

        // random traffic with random consumer stalls
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    push_rnd(TAG_W'($urandom));
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 io.out_ready = ($urandom_range(0, 3) != 0);
                end
                io.out_ready = 1'b1;
            end
        join

        for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
        chk("drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor with a valid/ready stream interface.
- Generalises the team's combinational half-precision adder:
  - configurable exponent/mantissa widths
  - add/subtract mode
  - exponent bias, guard/round/sticky alignment with round-to-nearest-even
  - Inf/NaN handling, exception flags
  - backpressure and a passthrough tag
- Sits between operand producers (FIFOs/DMA) and result consumers in the FP datapath.

Parameters:
EXP_W, 5, exponent field width
MAN_W, 10, stored mantissa width (hidden bit implicit)
TAG_W, 4, width of opaque sideband tag carried alongside each operation
(derived, not overridable) FLOAT_W = 1+EXP_W+MAN_W; BIAS = 2^(EXP_W-1)-1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
in_a  in  FLOAT_W  operand A
in_b  in  FLOAT_W  operand B
in_sub  in  1  1: compute A-B; 0: A+B
in_tag  in  TAG_W  sideband, returned unchanged with result
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_res  out  FLOAT_W  result
out_tag  out  TAG_W  tag of this result
out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Interface is clk plus rst. Reset is synchronous and active-high. On rst=1 at an edge:
  - all stage valid bits clear, so out_valid=0 from the next cycle
  - out_res, out_tag and out_flags are 0
  - any in-flight operations are discarded
- Pipeline: S1 unpack/special-detect/swap/align; S2 effective add or subtract; S3 normalise/round/pack. Latency is exactly 3 cycles from input handshake to out_valid with no stall.
- Handshake:
  - advance = !s3_valid || out_ready
  - in_ready = advance
  - On advance, all stages shift together; otherwise every stage holds.
  - Transfer occurs only when valid&&ready.
  - out_res, out_tag and out_flags stay stable while out_valid=1 and out_ready=0.
  - Throughput is 1 op/cycle when out_ready=1. Results emerge in input order.
- Unpack:
  - Effective sign of B = b_sign ^ in_sub.
  - Exponent field 0 is treated as signed zero; subnormal inputs flush to zero.
  - Exponent field all-ones with mantissa 0 is Inf; with mantissa nonzero it is NaN.
- Alignment:
  - Larger-magnitude operand goes first; compare {exp,man}.
  - The smaller significand is right-shifted by the exponent difference into MAN_W+1 bits plus guard, round and sticky. Sticky is the OR of all bits shifted out.
  - Shift saturates at MAN_W+3, which yields a pure sticky.
- Add/sub:
  - Effective add: a carry-out right-shifts the sum by 1 (sticky accumulates) and increments the exponent.
  - Effective sub: the larger magnitude minus the smaller gives a non-negative result. Result sign = sign of the larger-magnitude operand.
- Normalise: leading-one detect over the full significand; left-shift and decrement the exponent accordingly. Exponent arithmetic is held in EXP_W+2 signed bits.
- Rounding: round-to-nearest-even on guard/round/sticky. A rounding carry renormalises (exponent+1). inexact = guard|round|sticky before rounding.
- Overflow: a final exponent ≥ 2^EXP_W-1 gives signed Inf, with overflow=1 and inexact=1.
- Underflow: a final exponent ≤ 0 with a nonzero result gives signed zero, with underflow=1 and inexact=1.
- Special cases:
  - Any NaN operand gives canonical qNaN {0, all-ones, 1, 0…}, invalid=0.
  - Inf + (-Inf) as effective subtraction gives qNaN, invalid=1.
  - Inf with a finite operand gives that Inf.
  - Exact cancellation x-x gives +0.
  - (+0)+(+0) gives +0; (-0)+(-0) gives -0; (+0)+(-0) gives +0.
  - Zero with a finite x gives x exactly, no flags.
- Flags are per-result and non-sticky.

Test Plan:
- Basic add: 0x3C00 (1.0) + 0x4000 (2.0), in_sub=0, tag=5 -> out_res=0x4200, out_tag=5, flags=0000, out_valid exactly 3 cycles after handshake.
- Sub/cancellation and rounding:
  - 0x3C00 - 0x3C00 -> 0x0000.
  - 0x3C00 + 0x1000 (2^-11, tie) -> 0x3C00, inexact=1.
  - 0x3C01 + 0x1000 -> 0x3C02, inexact=1 (ties-to-even up).
- Exceptions:
  - 0x7BFF + 0x7BFF -> 0x7C00, overflow=1, inexact=1.
  - 0x7C00 - 0x7C00 -> 0x7E00, invalid=1.
  - 0x7E01 + 0x3C00 -> 0x7E00, invalid=0.
- Underflow: 0x0400 - 0x0600 (result -2^-15) -> 0x8000, underflow=1, inexact=1.
- Backpressure: stream 6 ops back-to-back with out_ready=0 for cycles 2-8 -> in_ready drops once 3 are in flight; results are held stable, and all 6 emerge in order with correct tags and no loss or duplication.
- Reset mid-flight: assert rst for 1 cycle with 3 ops in flight -> out_valid=0 the next cycle, no stale result ever appears, and the next op after reset returns correctly 3 cycles later.
